digit_scan_ctrl: RTL and testbench
==================================

// Module: digit_scan_ctrl
// PURPOSE
//   Time-multiplexed digit scanner. Drives the 2-bit select and enable inputs of the 2-to-4 decoder.
//   The decoder's one-hot outputs act as the 4 seven-segment anode strobes.
//   Cycles round-robin through the digits enabled in digit_mask. Each digit is held for PRESCALE clocks.
//   An optional blanking gap sits between digits to suppress ghosting.
// PARAMETERS
//   PRESCALE   100000  clocks each digit is shown (>=2); counter width $clog2(PRESCALE)
//   BLANK_CYC  16      clocks en is low between digits (>=1); used only with DIGIT_SCAN_BLANK_EN
// PORTS
//   clk         in   1  system clock; all state on rising edge
//   rst_n       in   1  asynchronous, active-low reset
//   run         in   1  1 = scan, 0 = go idle (display dark)
//   digit_mask  in   4  bit i = digit i participates in scan
//   sel         out  2  digit select to decoder (bit0 -> x0, bit1 -> x1)
//   en          out  1  decoder enable E; registered
//   tick        out  1  1-cycle pulse on every slot advance
// BEHAVIOUR
//   Reset: sel=0, en=0, tick=0, state=IDLE, counters=0; takes effect immediately (async) even mid-slot.
//   All outputs are registered. No combinational path from inputs to outputs.
//   States: IDLE, SHOW, BLANK.
//   IDLE
//     en=0, sel holds.
//     If run=1 and digit_mask!=0 at an edge: go to SHOW.
//     sel = lowest set bit of digit_mask, en=1 after that same edge. Latency 1 clock.
//   SHOW
//     en=1. Slot counter counts 0..PRESCALE-1.
//     At terminal count, with DIGIT_SCAN_BLANK_EN: go to BLANK, en=0, counter cleared.
//   BLANK
//     en=0 for BLANK_CYC clocks.
//     Then sel = next enabled digit, searching circularly from sel+1 (3 wraps to 0).
//     tick=1 for one clock, return to SHOW, en=1.
//   Single enabled digit: "next" is the same digit. sel is unchanged, tick still pulses, gap still applies.
//   Abort conditions, checked in SHOW or BLANK at every edge:
//     run=0 or digit_mask==0 -> IDLE next clock, en=0, sel held, no tick.
//     In SHOW, digit_mask[sel] cleared -> treated as terminal count on the next edge.
//   Mask changes otherwise take effect at the next advance search.
//   Priority when run drops and the slot ends on the same edge: run=0 wins. IDLE, no tick.
//   Restart from IDLE always begins a full slot at the lowest enabled digit.
// CONFIGURATION
//   DIGIT_SCAN_BLANK_EN defined
//     BLANK state and gap logic are compiled in, as described above.
//   DIGIT_SCAN_BLANK_EN undefined
//     No BLANK state. SHOW terminal count advances sel directly and pulses tick.
//     en stays 1 across the advance; sel changes on the same edge.
//     BLANK_CYC is ignored.
// STRUCTURE
//   Package digit_scan_pkg holds:
//     state encoding localparams ST_IDLE=2'd0, ST_SHOW=2'd1, ST_BLANK=2'd2
//     SEL_W=2, NDIG=4
//   Sub-module scan_next_sel is purely combinational:
//     inputs (cur_sel[1:0], mask[3:0], from_lowest)
//     output nxt_sel[1:0], circular priority pick starting at cur_sel+1, or at 0 when from_lowest.
//   The FSM, slot counter and blank counter live in digit_scan_ctrl.
// TESTING (sim: PRESCALE=4, BLANK_CYC=2)
//   1. Assert rst_n=0 mid-SHOW -> sel=0, en=0, tick=0 immediately. Outputs hold until rst_n=1.
//   2. BLANK_EN, mask=4'b1111, run=1 -> sel 0,1,2,3,0.
//      Each digit shows en=1 for 4 clks with en=0 for 2 clks between.
//      tick every 6 clks; full period 24 clks.
//   3. mask=4'b1010 -> sel alternates 1,3,1,3. Digits 0 and 2 are never selected.
//   4. mask=4'b0100 -> sel fixed at 2; en 4 high / 2 low; tick every 6 clks.
//   5. Drop run at SHOW count 2 -> en=0 next clk, sel held, no tick.
//      Re-raise run with mask=4'b0110 -> sel=1, en=1 after 1 clk, full 4-clk slot.
//   6. BLANK_EN undefined, mask=4'b1111 -> en constantly 1; sel advances every 4 clks; tick every 4 clks.

Source files
------------

// File: rtl/digit_scan_pkg.sv
// Shared types and constants for the digit scanner.
//   ST_*   : FSM state encodings (IDLE, SHOW, BLANK)
//   SEL_W  : width of the decoder select
//   NDIG   : number of scanned digits
package digit_scan_pkg;

  localparam int unsigned SEL_W = 2;
  localparam int unsigned NDIG  = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHOW  = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHOW  = ST_SHOW,
    BLANK = ST_BLANK
  } state_e;

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Control/strobe bundle between a display host and the digit scanner.
//   run, digit_mask : host -> scanner (scan enable, participating digits)
//   sel, en, tick   : scanner -> decoder / host (select, decoder enable, advance pulse)
interface digit_scan_ctrl_if;
  import digit_scan_pkg::*;

  logic             run;
  logic [NDIG-1:0]  digit_mask;
  logic [SEL_W-1:0] sel;
  logic             en;
  logic             tick;

  modport master (output run, digit_mask, input sel, en, tick);
  modport slave  (input run, digit_mask, output sel, en, tick);

endinterface

// File: rtl/scan_next_sel.sv
// Combinational circular priority pick of the next enabled digit.
//   cur_sel     : currently selected digit
//   mask        : enabled digits
//   from_lowest : 1 = search from digit 0, 0 = search from cur_sel+1 (wrapping)
//   nxt_sel     : first enabled digit found; cur_sel if mask is empty
module scan_next_sel
  import digit_scan_pkg::*;
(
  input  logic [SEL_W-1:0] cur_sel,
  input  logic [NDIG-1:0]  mask,
  input  logic             from_lowest,
  output logic [SEL_W-1:0] nxt_sel
);

  logic [SEL_W-1:0] start;
  logic [SEL_W-1:0] idx;
  logic             found;

  // Walk all digits starting at 'start'; the 2-bit index wraps 3 -> 0 naturally.
  always_comb begin
    start   = from_lowest ? '0 : SEL_W'(cur_sel + 1'b1);
    nxt_sel = cur_sel;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < int'(NDIG); i++) begin
      idx = SEL_W'(start + SEL_W'(i));
      if (!found && mask[idx]) begin
        nxt_sel = idx;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed seven-segment digit scanner driving a 2-to-4 decoder.
// Optional inter-digit blanking gap compiled in with DIGIT_SCAN_BLANK_EN.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.run        : 1 = scan, 0 = idle (dark)
//   bus.digit_mask : digits participating in the scan
//   bus.sel        : decoder select (registered)
//   bus.en         : decoder enable (registered)
//   bus.tick       : one-cycle pulse on each slot advance (registered)
module digit_scan_ctrl
  import digit_scan_pkg::*;
#(
  parameter int unsigned PRESCALE  = 100000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  digit_scan_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             en_q, en_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] nxt_sel;
  logic             from_lowest;
  logic             scan_ok;
  logic             slot_end;

`ifdef DIGIT_SCAN_BLANK_EN
  localparam int unsigned BLK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_CYC - 1);

  logic [BLK_W-1:0] bcnt_q, bcnt_d;
`else
  logic unused_blank_cfg;
  assign unused_blank_cfg = ^BLANK_CYC;
`endif

  // A restart from IDLE always picks the lowest enabled digit.
  assign from_lowest = (state_q == IDLE);
  assign scan_ok     = bus.run && (|bus.digit_mask);
  // Losing the shown digit from the mask ends its slot early.
  assign slot_end    = (cnt_q == CNT_LAST) || !bus.digit_mask[sel_q];

  scan_next_sel u_next_sel (
    .cur_sel     (sel_q),
    .mask        (bus.digit_mask),
    .from_lowest (from_lowest),
    .nxt_sel     (nxt_sel)
  );

  // Next-state and next-output logic; abort has priority over slot advance.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
`ifdef DIGIT_SCAN_BLANK_EN
    bcnt_d  = bcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (scan_ok) begin
          state_d = SHOW;
          sel_d   = nxt_sel;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (!scan_ok) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (slot_end) begin
          cnt_d   = '0;
`ifdef DIGIT_SCAN_BLANK_EN
          state_d = BLANK;
          bcnt_d  = '0;
`else
          sel_d   = nxt_sel;
          tick_d  = 1'b1;
`endif
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
`ifdef DIGIT_SCAN_BLANK_EN
      BLANK: begin
        if (!scan_ok) begin
          state_d = IDLE;
          bcnt_d  = '0;
        end else if (bcnt_q == BLK_LAST) begin
          state_d = SHOW;
          sel_d   = nxt_sel;
          tick_d  = 1'b1;
          bcnt_d  = '0;
        end else begin
          bcnt_d = BLK_W'(bcnt_q + 1'b1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    en_d = (state_d == SHOW);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      en_q    <= 1'b0;
      tick_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef DIGIT_SCAN_BLANK_EN
      bcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
`ifdef DIGIT_SCAN_BLANK_EN
      bcnt_q  <= bcnt_d;
`endif
    end
  end

  assign bus.sel  = sel_q;
  assign bus.en   = en_q;
  assign bus.tick = tick_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Self-checking bench for digit_scan_ctrl (works with or without DIGIT_SCAN_BLANK_EN).
module tb_digit_scan_ctrl;
  import digit_scan_pkg::*;

  localparam int unsigned PRESCALE  = 4;
  localparam int unsigned BLANK_CYC = 2;
`ifdef DIGIT_SCAN_BLANK_EN
  localparam int GAP = BLANK_CYC;
`else
  localparam int GAP = 0;
`endif
  localparam int PERIOD = PRESCALE + GAP;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  digit_scan_ctrl_if bus ();

  digit_scan_ctrl #(.PRESCALE(PRESCALE), .BLANK_CYC(BLANK_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: k = number of edges since the one that started the scan (k>=1).
  // Every slot lasts PERIOD clocks: PRESCALE lit, then GAP dark; digits taken in
  // ascending order of the enabled set, wrapping.
  function automatic logic m_en(int k);
    int ph;
    ph = (k - 1) % PERIOD;
    return ph < int'(PRESCALE);
  endfunction

  function automatic logic m_tick(int k);
    return (k > 1) && (((k - 1) % PERIOD) == 0);
  endfunction

  function automatic logic [1:0] m_sel(int k, logic [3:0] m);
    int s, n, want, seen;
    logic [1:0] r;
    s    = (k - 1) / PERIOD;
    n    = $countones(m);
    want = s % n;
    seen = 0;
    r    = 2'd0;
    for (int d = 0; d < 4; d++) begin
      if (m[d]) begin
        if (seen == want) r = 2'(d);
        seen++;
      end
    end
    return r;
  endfunction

  task automatic go_idle();
    bus.run = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    bus.run        = 1'b0;
    bus.digit_mask = 4'b0000;
    rst_n          = 1'b0;
    step();
    step();
    n_cmp++; if (bus.sel !== 2'd0) begin n_err++; $display("FAIL reset_sel got=%0d exp=0", bus.sel); end
    n_cmp++; if (bus.en !== 1'b0) begin n_err++; $display("FAIL reset_en got=%b exp=0", bus.en); end
    n_cmp++; if (bus.tick !== 1'b0) begin n_err++; $display("FAIL reset_tick got=%b exp=0", bus.tick); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_async_reset();
    bus.digit_mask = 4'b1111;
    bus.run        = 1'b1;
    for (int k = 1; k <= PERIOD + 2; k++) step();
    n_cmp++; if (bus.sel !== 2'd1 || bus.en !== 1'b1) begin
      n_err++; $display("FAIL pre_reset sel=%0d en=%b exp sel=1 en=1", bus.sel, bus.en);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.sel !== 2'd0 || bus.en !== 1'b0 || bus.tick !== 1'b0) begin
      n_err++; $display("FAIL async_reset sel=%0d en=%b tick=%b exp 0/0/0", bus.sel, bus.en, bus.tick);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (bus.sel !== 2'd0 || bus.en !== 1'b0 || bus.tick !== 1'b0) begin
        n_err++; $display("FAIL reset_hold sel=%0d en=%b tick=%b exp 0/0/0", bus.sel, bus.en, bus.tick);
      end
    end
    bus.run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++; if (bus.en !== 1'b0) begin n_err++; $display("FAIL post_reset_en got=%b exp=0", bus.en); end
  endtask

  task automatic test_round_robin();
    logic [3:0] masks [3];
    masks[0] = 4'b1111;
    masks[1] = 4'b1010;
    masks[2] = 4'b0100;
    for (int t = 0; t < 3; t++) begin
      go_idle();
      bus.digit_mask = masks[t];
      bus.run        = 1'b1;
      for (int k = 1; k <= 4 * PERIOD + 1; k++) begin
        step();
        n_cmp++; if (bus.en !== m_en(k) || bus.tick !== m_tick(k) || bus.sel !== m_sel(k, masks[t])) begin
          n_err++;
          $display("FAIL rr mask=%b k=%0d got sel=%0d en=%b tick=%b exp sel=%0d en=%b tick=%b",
                   masks[t], k, bus.sel, bus.en, bus.tick, m_sel(k, masks[t]), m_en(k), m_tick(k));
        end
      end
    end
    go_idle();
  endtask

  task automatic test_run_drop();
    logic [1:0] held;
    bus.digit_mask = 4'b1111;
    bus.run        = 1'b1;
    for (int k = 1; k <= PERIOD + 3; k++) step();
    held    = m_sel(PERIOD + 3, 4'b1111);
    bus.run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (bus.en !== 1'b0 || bus.tick !== 1'b0 || bus.sel !== held) begin
        n_err++; $display("FAIL run_drop i=%0d got sel=%0d en=%b tick=%b exp sel=%0d en=0 tick=0",
                          i, bus.sel, bus.en, bus.tick, held);
      end
    end
    bus.digit_mask = 4'b0110;
    bus.run        = 1'b1;
    for (int k = 1; k <= PERIOD + 1; k++) begin
      step();
      n_cmp++; if (bus.en !== m_en(k) || bus.tick !== m_tick(k) || bus.sel !== m_sel(k, 4'b0110)) begin
        n_err++; $display("FAIL restart k=%0d got sel=%0d en=%b tick=%b exp sel=%0d en=%b tick=%b",
                          k, bus.sel, bus.en, bus.tick, m_sel(k, 4'b0110), m_en(k), m_tick(k));
      end
    end
    go_idle();
  endtask

  task automatic test_drop_at_slot_end();
    int drop_k [2];
    drop_k[0] = PRESCALE;
    drop_k[1] = PERIOD;
    for (int t = 0; t < 2; t++) begin
      bus.digit_mask = 4'b1111;
      bus.run        = 1'b1;
      for (int k = 1; k <= drop_k[t]; k++) step();
      bus.run = 1'b0;
      step();
      n_cmp++; if (bus.en !== 1'b0 || bus.tick !== 1'b0 || bus.sel !== 2'd0) begin
        n_err++; $display("FAIL drop_end k=%0d got sel=%0d en=%b tick=%b exp sel=0 en=0 tick=0",
                          drop_k[t], bus.sel, bus.en, bus.tick);
      end
      go_idle();
    end
  endtask

  task automatic test_mask_clear();
    logic e_en, e_tick;
    logic [1:0] e_sel;
    bus.digit_mask = 4'b1111;
    bus.run        = 1'b1;
    step();
    step();
    bus.digit_mask = 4'b1110;
    for (int j = 1; j <= GAP + int'(PRESCALE); j++) begin
      step();
      e_en   = (j > GAP);
      e_tick = (j == GAP + 1);
      e_sel  = (j > GAP) ? 2'd1 : 2'd0;
      n_cmp++; if (bus.en !== e_en || bus.tick !== e_tick || bus.sel !== e_sel) begin
        n_err++; $display("FAIL mask_clear j=%0d got sel=%0d en=%b tick=%b exp sel=%0d en=%b tick=%b",
                          j, bus.sel, bus.en, bus.tick, e_sel, e_en, e_tick);
      end
    end
    go_idle();
  endtask

  task automatic test_mask_zero();
    bus.digit_mask = 4'b0000;
    bus.run        = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (bus.en !== 1'b0 || bus.tick !== 1'b0) begin
        n_err++; $display("FAIL zero_idle i=%0d got en=%b tick=%b exp 0/0", i, bus.en, bus.tick);
      end
    end
    bus.digit_mask = 4'b1100;
    step();
    step();
    bus.digit_mask = 4'b0000;
    step();
    n_cmp++; if (bus.en !== 1'b0 || bus.tick !== 1'b0 || bus.sel !== 2'd2) begin
      n_err++; $display("FAIL zero_abort got sel=%0d en=%b tick=%b exp sel=2 en=0 tick=0",
                        bus.sel, bus.en, bus.tick);
    end
    go_idle();
  endtask

  task automatic test_random();
    logic [3:0] m;
    logic [1:0] held;
    int len, idle;
    for (int it = 0; it < 20; it++) begin
      m   = 4'($urandom_range(1, 15));
      len = $urandom_range(1, 5 * PERIOD);
      bus.digit_mask = m;
      bus.run        = 1'b1;
      for (int k = 1; k <= len; k++) begin
        step();
        n_cmp++; if (bus.en !== m_en(k) || bus.tick !== m_tick(k) || bus.sel !== m_sel(k, m)) begin
          n_err++; $display("FAIL rnd it=%0d mask=%b k=%0d got sel=%0d en=%b tick=%b exp sel=%0d en=%b tick=%b",
                            it, m, k, bus.sel, bus.en, bus.tick, m_sel(k, m), m_en(k), m_tick(k));
        end
      end
      held    = m_sel(len, m);
      bus.run = 1'b0;
      if ($urandom_range(0, 1) == 1) bus.digit_mask = 4'($urandom_range(0, 15));
      idle = $urandom_range(1, 3);
      for (int i = 0; i < idle; i++) begin
        step();
        n_cmp++; if (bus.en !== 1'b0 || bus.tick !== 1'b0 || bus.sel !== held) begin
          n_err++; $display("FAIL rnd_idle it=%0d got sel=%0d en=%b tick=%b exp sel=%0d en=0 tick=0",
                            it, bus.sel, bus.en, bus.tick, held);
        end
      end
    end
  endtask

  initial begin
    bus.run        = 1'b0;
    bus.digit_mask = 4'b0000;
    test_reset();
    test_round_robin();
    test_run_drop();
    test_drop_at_slot_end();
    test_mask_clear();
    test_mask_zero();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
